// File: rtl/ahb_bfm_pkg.sv
// Shared AHB-Lite encodings, controller states and response payload for the
// ahb_cmd_master command-to-AHB bridge.
package ahb_bfm_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } ahb_state_e;

  // Response payload returned on the rsp port.
  typedef struct packed {
    logic        err;
    logic        timeout;
    logic [31:0] rdata;
  } ahb_rsp_t;

  // A command is legal when its size is byte/half/word and the address is
  // naturally aligned to that size.
  function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: turns a valid/ready command stream into single NONSEQ
// AHB-Lite transfers and returns one response per command.
// Optional build macro AHB_MASTER_TIMEOUT_EN adds an HREADY-low abort counter.
module ahb_cmd_master
  import ahb_bfm_pkg::*;
#(
  parameter int unsigned AWIDTH  = 10,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              busy
);

  // Reject configurations the timeout counter cannot represent.
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("ahb_cmd_master: TIMEOUT must be in 2..65535");
  end

  ahb_state_e        state_q;
  logic [AWIDTH-1:0] haddr_q;
  logic [1:0]        htrans_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [31:0]       hwdata_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q;
  ahb_rsp_t          rsp_q;
  logic              to_hit;

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt_q;

  // Count HREADY-low cycles; cleared in IDLE and on every phase entry.
  always_ff @(posedge HCLK) begin
    if (HRESET || state_q == IDLE || HREADY) begin
      to_cnt_q <= 16'd0;
    end else begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  assign to_hit = (state_q != IDLE) && !HREADY && (to_cnt_q == ToLast);
`else
  assign to_hit = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE) && !rsp_valid_q && !HRESET;
  assign busy      = (state_q != IDLE) || rsp_valid_q;

  // Transfer sequencer: command accept, address phase, data phase, response.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      hwdata_q    <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (cmd_legal(cmd_size, cmd_addr[1:0])) begin
              haddr_q  <= cmd_addr;
              hwrite_q <= cmd_write;
              hsize_q  <= cmd_size;
              wdata_q  <= cmd_wdata;
              htrans_q <= HTRANS_NONSEQ;
              state_q  <= ADDR;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_q       <= '{err: 1'b1, timeout: 1'b0, rdata: 32'd0};
            end
          end
        end
        ADDR: begin
          if (HREADY) begin
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= hwrite_q ? wdata_q : 32'd0;
            state_q  <= DATA;
          end else if (to_hit) begin
            htrans_q    <= HTRANS_IDLE;
            hwdata_q    <= 32'd0;
            rsp_valid_q <= 1'b1;
            rsp_q       <= '{err: 1'b1, timeout: 1'b1, rdata: 32'd0};
            state_q     <= IDLE;
          end
        end
        DATA: begin
          if (HREADY) begin
            hwdata_q    <= 32'd0;
            rsp_valid_q <= 1'b1;
            rsp_q       <= '{err: HRESP, timeout: 1'b0,
                             rdata: (!hwrite_q && !HRESP) ? HRDATA : 32'd0};
            state_q     <= IDLE;
          end else if (to_hit) begin
            htrans_q    <= HTRANS_IDLE;
            hwdata_q    <= 32'd0;
            rsp_valid_q <= 1'b1;
            rsp_q       <= '{err: 1'b1, timeout: 1'b1, rdata: 32'd0};
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HWDATA      = hwdata_q;
  assign HBURST      = HBURST_SINGLE;
  assign HMASTLOCK   = 1'b0;
  assign HPROT       = HPROT_DEFAULT;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Scoreboard bench for ahb_cmd_master; bus timing checked inline by the
// driver, responses checked by a monitor against queued expectations.
module tb_ahb_cmd_master;
  import ahb_bfm_pkg::*;

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int unsigned TbTimeout = 8;
`else
  localparam int unsigned TbTimeout = 256;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [9:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP, busy;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA, HRDATA;

  int n_checks = 0;
  int n_errors = 0;
  ahb_rsp_t sb[$];

  always #5 HCLK = ~HCLK;

  ahb_cmd_master #(.AWIDTH(10), .TIMEOUT(TbTimeout)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  // Response monitor: pop one expectation per completed rsp handshake.
  always @(negedge HCLK) begin : mon
    ahb_rsp_t e;
    if (!HRESET && rsp_valid && rsp_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
        check("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input string tag, input logic w, input logic [9:0] a,
                         input logic [2:0] sz, input logic [31:0] wd, input logic legal,
                         input int waits, input logic err, input logic [31:0] rd,
                         input logic hold);
    ahb_rsp_t exp;
    cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = wd; cmd_valid = 1'b1;
    rsp_ready = !hold; HREADY = 1'b1; HRESP = 1'b0;
    wait_ready(tag);
    if (legal) exp = '{err: err, timeout: 1'b0, rdata: (w || err) ? 32'd0 : rd};
    else       exp = '{err: 1'b1, timeout: 1'b0, rdata: 32'd0};
    sb.push_back(exp);
    tick;
    cmd_valid = 1'b0;
    if (!legal) begin
      check({tag, "_htrans_idle"}, 32'(HTRANS), 32'(HTRANS_IDLE));
      check({tag, "_rsp_1cyc"}, 32'(rsp_valid), 32'd1);
      tick;
      check({tag, "_htrans_after"}, 32'(HTRANS), 32'(HTRANS_IDLE));
      return;
    end
    check({tag, "_nonseq"}, 32'(HTRANS), 32'(HTRANS_NONSEQ));
    check({tag, "_haddr"}, 32'(HADDR), 32'(a));
    check({tag, "_hwrite"}, 32'(HWRITE), 32'(w));
    check({tag, "_hsize"}, 32'(HSIZE), 32'(sz));
    tick;
    check({tag, "_dph_idle"}, 32'(HTRANS), 32'(HTRANS_IDLE));
    check({tag, "_hwdata"}, HWDATA, w ? wd : 32'd0);
    for (int i = 0; i < waits; i++) begin
      HREADY = 1'b0;
      HRESP = err && (i == waits - 1);
      tick;
      check({tag, "_wait_idle"}, 32'(HTRANS), 32'(HTRANS_IDLE));
      check({tag, "_wait_norsp"}, 32'(rsp_valid), 32'd0);
    end
    HREADY = 1'b1; HRESP = err; HRDATA = rd;
    tick;
    HRESP = 1'b0; HRDATA = 32'hA5A5_5A5A;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_hwdata_clr"}, HWDATA, 32'd0);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_hold_rdata"}, rsp_rdata, exp.rdata);
        check({tag, "_hold_err"}, 32'(rsp_err), 32'(exp.err));
        check({tag, "_hold_cmdrdy"}, 32'(cmd_ready), 32'd0);
        tick;
      end
      rsp_ready = 1'b1;
      check({tag, "_clr_cmdrdy"}, 32'(cmd_ready), 32'd0);
    end
    tick;
    check({tag, "_rsp_clr"}, 32'(rsp_valid), 32'd0);
    check({tag, "_cmd_rdy_next"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; rsp_ready = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hA5A5_5A5A;
    tick;
    tick;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    check("rst_haddr", 32'(HADDR), 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("const_hburst", 32'(HBURST), 32'(HBURST_SINGLE));
    check("const_hprot", 32'(HPROT), 32'h3);
    check("const_hmastlock", 32'(HMASTLOCK), 32'd0);
    HRESET = 1'b0;
    tick;

    run_cmd("wr_word", 1'b1, 10'h040, HSIZE_WORD, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, 32'h0, 1'b0);
    run_cmd("rd_wait3", 1'b0, 10'h040, HSIZE_WORD, 32'h0, 1'b1, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
    run_cmd("wr_err", 1'b1, 10'h3FC, HSIZE_WORD, 32'h1234_5678, 1'b1, 1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_cmd("ill_align", 1'b1, 10'h002, HSIZE_WORD, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    run_cmd("ill_size", 1'b0, 10'h000, 3'd3, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    run_cmd("ill_half", 1'b0, 10'h041, HSIZE_HALF, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    run_cmd("rd_byte_hold", 1'b0, 10'h003, HSIZE_BYTE, 32'h0, 1'b1, 1, 1'b0, 32'h1234_5678, 1'b1);

    // Reset in the middle of a data phase discards the transfer.
    cmd_write = 1'b0; cmd_addr = 10'h080; cmd_size = HSIZE_WORD; cmd_valid = 1'b1;
    HREADY = 1'b1;
    wait_ready("rst_mid");
    tick;
    cmd_valid = 1'b0;
    tick;
    HREADY = 1'b0;
    tick;
    check("rst_mid_busy", 32'(busy), 32'd1);
    HRESET = 1'b1;
    tick;
    check("rst_mid_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    check("rst_mid_haddr", 32'(HADDR), 32'd0);
    HRESET = 1'b0; HREADY = 1'b1; HRDATA = 32'hCAFE_F00D;
    tick;
    HRDATA = 32'hA5A5_5A5A;
    check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_mid_busy_clr", 32'(busy), 32'd0);

    run_cmd("wr_half", 1'b1, 10'h102, HSIZE_HALF, 32'hBEEF_0000, 1'b1, 2, 1'b0, 32'h0, 1'b0);

`ifdef AHB_MASTER_TIMEOUT_EN
    // HREADY stuck low in the data phase aborts after TIMEOUT low cycles.
    cmd_write = 1'b0; cmd_addr = 10'h010; cmd_size = HSIZE_WORD; cmd_valid = 1'b1;
    HREADY = 1'b1;
    wait_ready("to");
    sb.push_back('{err: 1'b1, timeout: 1'b1, rdata: 32'd0});
    tick;
    cmd_valid = 1'b0;
    tick;
    HREADY = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (i < 8) check("to_pending", 32'(rsp_valid), 32'd0);
    end
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    HREADY = 1'b1;
    tick;
    check("to_rsp_clr", 32'(rsp_valid), 32'd0);
    run_cmd("to_after", 1'b0, 10'h020, HSIZE_WORD, 32'h0, 1'b1, 0, 1'b0, 32'h0BAD_CAFE, 1'b0);
`endif

    tick;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
